// File: rtl/fifo_demo_pkg.sv
// Shared types and default sizes for the dual-clock FIFO demo read side.
// Pure declarations; no latency or flow control of its own.
package fifo_demo_pkg;
  typedef enum logic [1:0] {IDLE, BURST, FLUSH} state_e;

  localparam int DATA_WIDTH_DEF  = 8;
  localparam int DEPTH_WIDTH_DEF = 8;
  localparam int BURST_LEN_DEF   = 16;
endpackage

// File: rtl/fifo_skid_buf.sv
// Small circular buffer holding FIFO words between read pipeline and stream; 1-cycle push-to-head.
// No internal backpressure: the caller guarantees push never lands on a full buffer without a pop.
module fifo_skid_buf #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 9
) (
  input  logic                       rd_clk,
  input  logic                       rd_rst_n,
  input  logic                       push_i,
  input  logic [WIDTH-1:0]           push_dat_i,
  input  logic                       pop_i,
  output logic [WIDTH-1:0]           head_dat_o,
  output logic [$clog2(DEPTH+1)-1:0] occ_o,
  output logic                       full_o,
  output logic                       empty_o
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int OW = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [OW-1:0]    occ_q;
  logic             do_pop;

  assign do_pop     = pop_i && !empty_o;
  assign empty_o    = (occ_q == '0);
  assign full_o     = (occ_q == OW'(DEPTH));
  assign occ_o      = occ_q;
  assign head_dat_o = mem_q[rd_ptr_q];

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH-1)) ? '0 : p + PW'(1);
  endfunction

  always_ff @(posedge rd_clk or negedge rd_rst_n) begin
    if (!rd_rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      if (push_i) begin
        mem_q[wr_ptr_q] <= push_dat_i;
        wr_ptr_q        <= ptr_inc(wr_ptr_q);
      end
      if (do_pop) rd_ptr_q <= ptr_inc(rd_ptr_q);
      case ({push_i, do_pop})
        2'b10:   occ_q <= occ_q + OW'(1);
        2'b01:   occ_q <= occ_q - OW'(1);
        default: occ_q <= occ_q;
      endcase
    end
  end
endmodule

// File: rtl/fifo_burst_reader.sv
// Drains the FIFO in BURST_LEN bursts onto a valid/ready stream and checks the incrementing pattern.
// First word RD_LATENCY+1 cycles after first rd_en; m_ready low throttles reads via skid credits.
module fifo_burst_reader
  import fifo_demo_pkg::*;
#(
  parameter int DATA_WIDTH  = DATA_WIDTH_DEF,
  parameter int DEPTH_WIDTH = DEPTH_WIDTH_DEF,
  parameter int BURST_LEN   = BURST_LEN_DEF,
  parameter int RD_LATENCY  = 2,
  parameter int SKID_DEPTH  = 4,
  parameter int CHECK_EN    = 1
) (
  input  logic                   rd_clk,
  input  logic                   rd_rst_n,
  input  logic                   enable,
  output logic                   rd_en,
  input  logic [DATA_WIDTH-1:0]  rd_data,
  input  logic                   rd_empty,
  input  logic [DEPTH_WIDTH:0]   rd_water_level,
  output logic                   m_valid,
  input  logic                   m_ready,
  output logic [DATA_WIDTH-1:0]  m_data,
  output logic                   m_last,
  output logic                   busy,
  output logic [15:0]            burst_cnt,
  output logic                   err_flag,
  output logic [15:0]            err_cnt
);
  localparam int OW = $clog2(SKID_DEPTH+1);
  localparam int CW = OW + 1;
  localparam int IW = DEPTH_WIDTH + 1;

  state_e                state_q, state_d;
  logic [IW-1:0]         issued_q, issued_d;
  logic [RD_LATENCY-1:0] pipe_vld_q, pipe_vld_d, pipe_last_q, pipe_last_d;
  logic [DATA_WIDTH-1:0] exp_q, exp_d;
  logic                  err_flag_q, err_flag_d;
  logic [15:0]           err_cnt_q, err_cnt_d, burst_cnt_q, burst_cnt_d;
  logic [CW-1:0]         inflight;
  logic [OW-1:0]         occ;
  logic                  sb_full, sb_empty, cap, rd_last;
  logic [DATA_WIDTH:0]   head;

  assign cap     = pipe_vld_q[RD_LATENCY-1];
  assign rd_last = (issued_q == IW'(BURST_LEN-1));

  always_comb begin
    inflight = '0;
    for (int i = 0; i < RD_LATENCY; i++) inflight = inflight + CW'(pipe_vld_q[i]);
  end

  always_comb begin
    state_d     = state_q;
    issued_d    = issued_q;
    burst_cnt_d = burst_cnt_q;
    rd_en       = 1'b0;
    case (state_q)
      IDLE: if (enable && !rd_empty && rd_water_level >= IW'(BURST_LEN)) begin
        state_d  = BURST;
        issued_d = '0;
      end
      BURST: begin
        // Reads in flight plus buffered words may not exceed the buffer size.
        rd_en = !rd_empty && (issued_q < IW'(BURST_LEN)) &&
                (inflight + CW'(occ) < CW'(SKID_DEPTH));
        if (rd_en) begin
          issued_d = issued_q + IW'(1);
          if (rd_last) state_d = FLUSH;
        end
      end
      FLUSH: if (inflight == '0) begin
        state_d     = IDLE;
        burst_cnt_d = burst_cnt_q + 16'd1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    pipe_vld_d     = '0;
    pipe_last_d    = '0;
    pipe_vld_d[0]  = rd_en;
    pipe_last_d[0] = rd_en && rd_last;
    for (int i = 1; i < RD_LATENCY; i++) begin
      pipe_vld_d[i]  = pipe_vld_q[i-1];
      pipe_last_d[i] = pipe_last_q[i-1];
    end
  end

  // Expected value always follows the received word so one drop costs one error.
  always_comb begin
    exp_d      = exp_q;
    err_flag_d = err_flag_q;
    err_cnt_d  = err_cnt_q;
    if (cap) begin
      if (rd_data != exp_q) begin
        err_flag_d = 1'b1;
        if (err_cnt_q != 16'hFFFF) err_cnt_d = err_cnt_q + 16'd1;
      end
      exp_d = rd_data + DATA_WIDTH'(1);
    end
  end

  always_ff @(posedge rd_clk or negedge rd_rst_n) begin
    if (!rd_rst_n) begin
      state_q     <= IDLE;
      issued_q    <= '0;
      pipe_vld_q  <= '0;
      pipe_last_q <= '0;
      exp_q       <= '0;
      err_flag_q  <= 1'b0;
      err_cnt_q   <= '0;
      burst_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      issued_q    <= issued_d;
      pipe_vld_q  <= pipe_vld_d;
      pipe_last_q <= pipe_last_d;
      exp_q       <= exp_d;
      err_flag_q  <= err_flag_d;
      err_cnt_q   <= err_cnt_d;
      burst_cnt_q <= burst_cnt_d;
    end
  end

  always_ff @(posedge rd_clk) begin
    if (rd_rst_n) assert (!(cap && sb_full && !(m_valid && m_ready)))
      else $error("skid buffer overflow");
  end

  fifo_skid_buf #(
    .DEPTH (SKID_DEPTH),
    .WIDTH (DATA_WIDTH+1)
  ) u_skid (
    .rd_clk     (rd_clk),
    .rd_rst_n   (rd_rst_n),
    .push_i     (cap),
    .push_dat_i ({pipe_last_q[RD_LATENCY-1], rd_data}),
    .pop_i      (m_valid && m_ready),
    .head_dat_o (head),
    .occ_o      (occ),
    .full_o     (sb_full),
    .empty_o    (sb_empty)
  );

  assign m_valid   = !sb_empty;
  assign m_data    = head[DATA_WIDTH-1:0];
  assign m_last    = head[DATA_WIDTH];
  assign busy      = (state_q != IDLE);
  assign burst_cnt = burst_cnt_q;
  assign err_flag  = (CHECK_EN != 0) && err_flag_q;
  assign err_cnt   = (CHECK_EN != 0) ? err_cnt_q : 16'd0;
endmodule

// File: tb/tb_fifo_burst_reader.sv
// Directed bench for fifo_burst_reader against a registered-output FIFO model (read latency 2).
module tb_fifo_burst_reader;
  logic       clk = 1'b0, rst_n = 1'b0, enable = 1'b0, m_ready = 1'b0;
  logic       rd_en, rd_empty, m_valid, m_last, busy, err_flag;
  logic [7:0] m_data;
  logic [7:0] rd_data = 8'd0, d1 = 8'd0;
  logic [8:0] rd_water_level;
  logic [15:0] burst_cnt, err_cnt;

  logic [7:0] mem [256];
  logic [7:0] got_dat [256];
  logic       got_last [256];
  int wr_ptr = 0, rd_ptr = 0, gap_ptr = 0;
  logic gap_on = 1'b0;
  int tests = 0, fails = 0, n_got = 0, bad_rden = 0, rd_en_cnt = 0;
  int base, r0;

  fifo_burst_reader dut (
    .rd_clk         (clk),
    .rd_rst_n       (rst_n),
    .enable         (enable),
    .rd_en          (rd_en),
    .rd_data        (rd_data),
    .rd_empty       (rd_empty),
    .rd_water_level (rd_water_level),
    .m_valid        (m_valid),
    .m_ready        (m_ready),
    .m_data         (m_data),
    .m_last         (m_last),
    .busy           (busy),
    .burst_cnt      (burst_cnt),
    .err_flag       (err_flag),
    .err_cnt        (err_cnt)
  );

  always #5 clk = ~clk;

  // gap_on hides words past gap_ptr, emulating the read side briefly seeing empty.
  assign rd_empty       = (rd_ptr == (gap_on ? gap_ptr : wr_ptr));
  assign rd_water_level = 9'((gap_on ? gap_ptr : wr_ptr) - rd_ptr);

  always @(posedge clk) begin
    if (rd_en) begin
      d1     <= mem[rd_ptr[7:0]];
      rd_ptr <= rd_ptr + 1;
    end
    rd_data <= d1;
  end

  always @(negedge clk) begin
    if (rst_n) begin
      if (m_valid && m_ready && n_got < 256) begin
        got_dat[n_got]  = m_data;
        got_last[n_got] = m_last;
        n_got++;
      end
      if (rd_en && rd_empty) bad_rden++;
      if (rd_en) rd_en_cnt++;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push(input logic [7:0] v);
    mem[wr_ptr[7:0]] = v;
    wr_ptr++;
  endtask

  task automatic wait_bursts(input int n, input string tag);
    for (int k = 0; k < 300 && burst_cnt != 16'(n); k++) tick(1);
    chk(tag, 32'(burst_cnt), 32'(n));
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_rd_en"},     32'(rd_en), 0);
    chk({tag, "_m_valid"},   32'(m_valid), 0);
    chk({tag, "_m_data"},    32'(m_data), 0);
    chk({tag, "_m_last"},    32'(m_last), 0);
    chk({tag, "_busy"},      32'(busy), 0);
    chk({tag, "_burst_cnt"}, 32'(burst_cnt), 0);
    chk({tag, "_err_flag"},  32'(err_flag), 0);
    chk({tag, "_err_cnt"},   32'(err_cnt), 0);
  endtask

  initial begin
    #2;
    chk_zero("reset");
    tick(2);
    rst_n = 1'b1;

    // Two back-to-back bursts of 0..31.
    base = n_got;
    for (int i = 0; i < 32; i++) push(8'(i));
    enable  = 1'b1;
    m_ready = 1'b1;
    wait_bursts(2, "t1_bursts");
    tick(4);
    chk("t1_count", n_got - base, 32);
    for (int i = 0; i < 32; i++) begin
      chk("t1_data", 32'(got_dat[base+i]), i);
      chk("t1_last", 32'(got_last[base+i]), 32'(i % 16 == 15));
    end
    chk("t1_err_cnt", 32'(err_cnt), 0);
    chk("t1_idle", 32'(busy), 0);

    // Level 15 must not start; the 16th word starts a burst next cycle.
    base = n_got;
    for (int i = 0; i < 15; i++) push(8'(32 + i));
    tick(5);
    chk("t2_busy_lvl15", 32'(busy), 0);
    chk("t2_rden_lvl15", 32'(rd_en), 0);
    chk("t2_nodata", n_got - base, 0);
    push(8'd47);
    tick(1);
    chk("t2_start", 32'(busy), 1);
    wait_bursts(3, "t2_bursts");
    tick(4);
    chk("t2_count", n_got - base, 16);
    for (int i = 0; i < 16; i++) begin
      chk("t2_data", 32'(got_dat[base+i]), 32 + i);
      chk("t2_last", 32'(got_last[base+i]), 32'(i == 15));
    end

    // Downstream stall: only SKID_DEPTH reads may be issued.
    base    = n_got;
    m_ready = 1'b0;
    r0      = rd_en_cnt;
    for (int i = 0; i < 16; i++) push(8'(48 + i));
    tick(20);
    chk("t3_reads", rd_en_cnt - r0, 4);
    chk("t3_valid", 32'(m_valid), 1);
    chk("t3_head", 32'(m_data), 48);
    chk("t3_nodata", n_got - base, 0);
    m_ready = 1'b1;
    wait_bursts(4, "t3_bursts");
    tick(4);
    chk("t3_count", n_got - base, 16);
    for (int i = 0; i < 16; i++) begin
      chk("t3_data", 32'(got_dat[base+i]), 48 + i);
      chk("t3_last", 32'(got_last[base+i]), 32'(i == 15));
    end

    // FIFO runs dry after 10 words, refills 5 cycles later.
    base = n_got;
    for (int i = 0; i < 16; i++) push(8'(64 + i));
    tick(1);
    chk("t4_start", 32'(busy), 1);
    gap_ptr = rd_ptr + 10;
    gap_on  = 1'b1;
    for (int k = 0; k < 40 && rd_ptr != gap_ptr; k++) tick(1);
    chk("t4_reads", rd_ptr - base, 32'(gap_ptr - base));
    tick(5);
    chk("t4_gap_rden", 32'(rd_en), 0);
    chk("t4_gap_busy", 32'(busy), 1);
    chk("t4_gap_words", n_got - base, 10);
    chk("t4_gap_bursts", 32'(burst_cnt), 4);
    gap_on = 1'b0;
    wait_bursts(5, "t4_bursts");
    tick(4);
    chk("t4_count", n_got - base, 16);
    for (int i = 0; i < 16; i++) begin
      chk("t4_data", 32'(got_dat[base+i]), 64 + i);
      chk("t4_last", 32'(got_last[base+i]), 32'(i == 15));
    end

    // Reset asserted while the burst is flushing.
    r0 = rd_ptr;
    for (int i = 0; i < 16; i++) push(8'(80 + i));
    for (int k = 0; k < 60 && rd_ptr != r0 + 16; k++) tick(1);
    chk("t5_reads", rd_ptr - r0, 16);
    chk("t5_flush_busy", 32'(busy), 1);
    rst_n = 1'b0;
    #1;
    chk_zero("t5_rst");
    tick(2);
    rst_n = 1'b1;

    // Checker restarts at 0; word 7 corrupted to 99.
    base = n_got;
    for (int i = 0; i < 32; i++) push((i == 7) ? 8'd99 : 8'(i));
    wait_bursts(2, "t6_bursts");
    tick(4);
    chk("t6_err_cnt", 32'(err_cnt), 2);
    chk("t6_err_flag", 32'(err_flag), 1);
    chk("t6_count", n_got - base, 32);
    for (int i = 0; i < 32; i++) begin
      chk("t6_data", 32'(got_dat[base+i]), (i == 7) ? 99 : i);
      chk("t6_last", 32'(got_last[base+i]), 32'(i % 16 == 15));
    end

    chk("rden_while_empty", bad_rden, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/fifo_burst_reader.md
Name: fifo_burst_reader

Overview:
- Read-side consumer for the dual-clock FIFO IP in the demo designs.
- Watches the FIFO read water level and drains the FIFO in fixed-length bursts, honouring the FIFO's registered-output read latency.
- Presents each word on a valid/ready stream with an end-of-burst marker.
- Checks the data against the incrementing test pattern written on the write side and reports errors.

Parameters:
- DATA_WIDTH, 8: FIFO read data width and stream width.
- DEPTH_WIDTH, 8: FIFO read depth width. Water level is DEPTH_WIDTH+1 bits.
- BURST_LEN, 16: words per burst. Legal range 1..2^DEPTH_WIDTH.
- RD_LATENCY, 2: cycles from an rd_en=1 cycle to the corresponding rd_data being valid. Value 2 matches the output-register-enabled FIFO; legal values are 1 or 2.
- SKID_DEPTH, 4: entries in the output buffer. Must be >= RD_LATENCY+1; this value gives full throughput.
- CHECK_EN, 1: 1 enables the pattern checker; 0 ties err_flag and err_cnt to 0.

Ports:
- rd_clk, input, 1: FIFO read clock. This is the only clock in the block.
- rd_rst_n, input, 1: asynchronous, active-low reset.
- enable, input, 1: permits starting new bursts.
- rd_en, output, 1: FIFO read enable.
- rd_data, input, DATA_WIDTH: FIFO read data.
- rd_empty, input, 1: FIFO empty flag.
- rd_water_level, input, DEPTH_WIDTH+1: FIFO read-side fill level.
- m_valid, output, 1: stream word valid.
- m_ready, input, 1: downstream accepts the word.
- m_data, output, DATA_WIDTH: stream data.
- m_last, output, 1: marks the last word of a burst.
- busy, output, 1: high in any state other than IDLE.
- burst_cnt, output, 16: number of completed bursts. Wraps.
- err_flag, output, 1: sticky pattern-mismatch flag.
- err_cnt, output, 16: mismatch count, saturating at 16'hFFFF.

Behaviour:
- Reset (rd_rst_n=0, asynchronous):
  - All outputs go to 0: rd_en, m_valid, m_data, m_last, busy, burst_cnt, err_flag, err_cnt.
  - FSM enters IDLE.
  - issued count, in-flight pipe and skid buffer are cleared.
  - Expected pattern value is set to 0.
- FSM states: IDLE, BURST, FLUSH.
- IDLE -> BURST when enable=1, rd_water_level >= BURST_LEN and rd_empty=0. issued is cleared on entry.
- BURST:
  - rd_en = !rd_empty && (issued < BURST_LEN) && (inflight + occupancy < SKID_DEPTH).
  - rd_en is combinational from registered state and FIFO flags. It must never be 1 while rd_empty=1.
  - issued increments on each rd_en cycle.
  - When the issued count reaches BURST_LEN, go to FLUSH.
- FLUSH: wait until inflight==0, then return to IDLE, increment burst_cnt and pulse nothing else.
- enable deasserted mid-burst: the current burst completes in full; no new burst starts.
- rd_empty asserted mid-burst: rd_en is held low and the FSM stays in BURST. This is a stall, not an abort.
- Read pipeline:
  - A shift register of RD_LATENCY valid bits, each tagged with a last bit; last = (the rd_en is the BURST_LEN-th of the burst).
  - When a tagged bit exits the shift register, rd_data is written into the skid buffer together with its last bit.
  - inflight is the number of set bits in the shift register.
- Credit rule: inflight + occupancy never exceeds SKID_DEPTH, so the skid buffer never overflows. Overflow is an assertion failure in simulation.
- Stream:
  - m_valid = buffer not empty; m_data and m_last come from the buffer head.
  - A word pops when m_valid && m_ready.
  - A simultaneous push and pop leaves occupancy unchanged.
  - m_valid, once high, holds its data stable until accepted.
- Checker (evaluated on each capture from the pipeline):
  - If rd_data != expected: err_flag is set (sticky until reset) and err_cnt increments, saturating.
  - In all cases expected becomes rd_data+1, modulo 2^DATA_WIDTH. The checker resyncs after an error, so one dropped word counts as one error.
- Throughput: with m_ready=1 and the FIFO non-empty, one word per cycle. First m_valid appears RD_LATENCY+1 cycles after the first rd_en.

Decomposition:
- Shared package fifo_demo_pkg holds:
  - the FSM state enumeration (IDLE/BURST/FLUSH);
  - the default widths DATA_WIDTH and DEPTH_WIDTH;
  - the constant BURST_LEN_DEF.
- One sub-module, fifo_skid_buf: synchronous buffer, SKID_DEPTH x (DATA_WIDTH+1), with push, pop, occupancy, full and empty. It uses the same rd_clk/rd_rst_n.

Test Plan:
- FIFO model preloaded with 0..31, enable=1, m_ready=1, BURST_LEN=16 -> two bursts. m_data sequence is 0..31 with m_last on 15 and 31. burst_cnt=2, err_cnt=0, rd_en never high while rd_empty=1.
- Water level 15 with enable=1 -> stays in IDLE, rd_en=0, busy=0. Write one more word (level 16) -> a burst starts within 1 cycle.
- m_ready held low for 20 cycles mid-burst -> at most SKID_DEPTH=4 reads issued, no skid overflow, no lost words. After release the sequence continues contiguously.
- FIFO model goes empty after 10 words of a burst, then refills 5 cycles later -> rd_en is low during the gap, the burst resumes, and m_last lands on the 16th word.
- Preload the pattern with value 7 replaced by 99 -> err_cnt=2 (at 99, then at 8 vs expected 100), err_flag=1, and no further errors after resync.
- rd_rst_n pulsed low during FLUSH -> all outputs go to 0 immediately and the FSM is in IDLE. After reset, the checker expects 0 again.
